// File: rtl/tlb_set_assoc_pkg.sv
// Shared types for the set-associative TLB: privilege encoding, entry layout
// and flush controller states.
package tlb_set_assoc_pkg;

  // Entry fields are sized for the widest supported page numbers; narrower
  // instances zero-extend on write and the unused upper flops are constant.
  localparam int ENTRY_VPN_W = 32;
  localparam int ENTRY_PPN_W = 32;

  typedef enum logic {
    PRIV_USER       = 1'b0,
    PRIV_SUPERVISOR = 1'b1
  } priv_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } flush_state_e;

  typedef struct packed {
    logic                   valid;
    logic [ENTRY_VPN_W-1:0] vpn;
    logic [ENTRY_PPN_W-1:0] ppn;
    logic                   write_priv;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_plru.sv
// Per-set tree pseudo-LRU: a hit and a fill may both touch a set in one cycle
// (fill applied last), and a per-set clear supports the sequential flush.
module tlb_plru #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  localparam int SET_W  = $clog2(NUM_SETS),
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int TREE_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_en,
  input  logic [SET_W-1:0] clear_set,
  input  logic             hit_en,
  input  logic [SET_W-1:0] hit_set,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             fill_en,
  input  logic [SET_W-1:0] fill_set,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [SET_W-1:0] victim_set,
  output logic [WAY_W-1:0] victim_way
);

  logic [TREE_W-1:0] tree_q [NUM_SETS];
  logic [TREE_W-1:0] tree_d [NUM_SETS];

  // Node n has children 2n+1 / 2n+2; a 0 bit sends the victim search left.
  // Touching a way points every node on its path away from it.
  function automatic logic [TREE_W-1:0] touch(input logic [TREE_W-1:0] bits,
                                              input logic [WAY_W-1:0]  way);
    logic [TREE_W-1:0] res;
    logic              dir;
    logic              away;
    int                node;
    res  = bits;
    node = 0;
    if (NUM_WAYS > 1) begin
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
        dir  = 1'(way >> (WAY_W - 1 - lvl));
        away = ~dir;
        res  = (res & ~(TREE_W'(1) << node)) | (TREE_W'(away) << node);
        node = 2 * node + 1 + int'(dir);
      end
    end
    return res;
  endfunction

  always_comb begin
    logic [TREE_W-1:0] bits;
    logic              dir;
    int                node;
    bits       = tree_q[victim_set];
    victim_way = '0;
    dir        = 1'b0;
    node       = 0;
    if (NUM_WAYS > 1) begin
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
        dir        = 1'(bits >> node);
        victim_way = WAY_W'((victim_way << 1) | WAY_W'(dir));
        node       = 2 * node + 1 + int'(dir);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      tree_d[s] = tree_q[s];
      if (clear_en && clear_set == SET_W'(s)) begin
        tree_d[s] = '0;
      end else begin
        if (hit_en && hit_set == SET_W'(s))   tree_d[s] = touch(tree_d[s], hit_way);
        if (fill_en && fill_set == SET_W'(s)) tree_d[s] = touch(tree_d[s], fill_way);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

endmodule

// File: rtl/tlb_set_assoc.sv
// Set-associative TLB with registered lookup, in-place/free/PLRU fill policy,
// Supervisor identity bypass and a one-set-per-cycle flush engine.
module tlb_set_assoc import tlb_set_assoc_pkg::*; #(
  parameter int VADDR_W    = 32,
  parameter int PADDR_W    = 20,
  parameter int PAGE_OFF_W = 12,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [VADDR_W-1:0]            req_virt_addr,
  input  logic                          priv_mode,
  output logic                          rsp_valid,
  output logic                          tlb_miss,
  output logic [PADDR_W-1:0]            rsp_phy_addr,
  output logic                          rsp_write_priv,
  input  logic                          fill_valid,
  input  logic [VADDR_W-PAGE_OFF_W-1:0] fill_vpn,
  input  logic [PADDR_W-PAGE_OFF_W-1:0] fill_ppn,
  input  logic                          fill_write_priv,
  input  logic                          flush_req,
  output logic                          flush_busy
);

  localparam int VPN_W = VADDR_W - PAGE_OFF_W;
  localparam int PPN_W = PADDR_W - PAGE_OFF_W;
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  tlb_entry_t       table_q [NUM_SETS][NUM_WAYS];
  flush_state_e     state_q, state_d;
  logic [SET_W-1:0] flush_set_q;

  logic [VPN_W-1:0] req_vpn;
  logic [SET_W-1:0] req_set, fill_set;
  logic             is_user, lookup_hit, user_hit, fill_en;
  logic             fill_match, fill_free;
  logic [WAY_W-1:0] hit_way, match_way, free_way, victim_way, fill_way;
  tlb_entry_t       hit_entry;

  assign req_vpn  = req_virt_addr[VADDR_W-1:PAGE_OFF_W];
  assign req_set  = req_vpn[SET_W-1:0];
  assign fill_set = fill_vpn[SET_W-1:0];
  assign is_user  = (priv_mode_e'(priv_mode) == PRIV_USER);
  assign user_hit = req_valid && is_user && !flush_busy && lookup_hit;
  // A flush request in the same cycle takes precedence over a fill.
  assign fill_en  = fill_valid && (state_q == ST_IDLE) && !flush_req;

  always_comb begin
    state_d    = state_q;
    flush_busy = (state_q == ST_FLUSH);
    case (state_q)
      ST_IDLE:  if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_set_q == SET_W'(NUM_SETS - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_set_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FLUSH) flush_set_q <= flush_set_q + 1'b1;
    end
  end

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    hit_entry  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (table_q[req_set][w].valid && table_q[req_set][w].vpn == ENTRY_VPN_W'(req_vpn)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
        hit_entry  = table_q[req_set][w];
      end
    end
  end

  // Fill way priority: existing copy of the vpn, lowest free way, PLRU victim.
  always_comb begin
    fill_match = 1'b0;
    fill_free  = 1'b0;
    match_way  = '0;
    free_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (table_q[fill_set][w].valid && !fill_match &&
          table_q[fill_set][w].vpn == ENTRY_VPN_W'(fill_vpn)) begin
        fill_match = 1'b1;
        match_way  = WAY_W'(w);
      end
      if (!table_q[fill_set][w].valid && !fill_free) begin
        fill_free = 1'b1;
        free_way  = WAY_W'(w);
      end
    end
    fill_way = fill_match ? match_way : (fill_free ? free_way : victim_way);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) table_q[s][w].valid <= 1'b0;
    end else if (state_q == ST_FLUSH) begin
      for (int w = 0; w < NUM_WAYS; w++) table_q[flush_set_q][w].valid <= 1'b0;
    end else if (fill_en) begin
      table_q[fill_set][fill_way] <= '{valid:      1'b1,
                                       vpn:        ENTRY_VPN_W'(fill_vpn),
                                       ppn:        ENTRY_PPN_W'(fill_ppn),
                                       write_priv: fill_write_priv};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid      <= 1'b0;
      tlb_miss       <= 1'b0;
      rsp_phy_addr   <= '0;
      rsp_write_priv <= 1'b0;
    end else begin
      rsp_valid      <= req_valid;
      tlb_miss       <= 1'b0;
      rsp_phy_addr   <= '0;
      rsp_write_priv <= 1'b0;
      if (req_valid) begin
        if (!is_user) begin
          rsp_phy_addr   <= req_virt_addr[PADDR_W-1:0];
          rsp_write_priv <= 1'b1;
        end else if (user_hit) begin
          rsp_phy_addr   <= {hit_entry.ppn[PPN_W-1:0], req_virt_addr[PAGE_OFF_W-1:0]};
          rsp_write_priv <= hit_entry.write_priv;
        end else begin
          tlb_miss <= 1'b1;
        end
      end
    end
  end

  tlb_plru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .clock      (clock),
    .reset      (reset),
    .clear_en   (state_q == ST_FLUSH),
    .clear_set  (flush_set_q),
    .hit_en     (user_hit),
    .hit_set    (req_set),
    .hit_way    (hit_way),
    .fill_en    (fill_en),
    .fill_set   (fill_set),
    .fill_way   (fill_way),
    .victim_set (fill_set),
    .victim_way (victim_way)
  );

endmodule
